// File: rtl/serial_param_loader.sv
// rtl/serial_param_loader.sv - UART frame receiver that loads pulse-sequencer parameters on a checksummed frame
module serial_param_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          TIMEOUT_CLKS = 120000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        pu,
    output logic [7:0]  per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic        cp,
    output logic        bl,
    output logic        rxd,
    output logic        frame_err
);
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int TCW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_SYNC, P_PAYLOAD, P_CSUM} p_state_t;

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t      r_state, r_next;
    logic [BCW-1:0] bit_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     rx_shift;
    logic           tick_half, tick_bit;
    logic           byte_valid, byte_ferr;

    assign tick_half = (bit_cnt == HALF_LAST);
    assign tick_bit  = (bit_cnt == BIT_LAST);

    // Falling-edge arming means a framing error naturally waits for the line to go high again.
    always_comb begin
        r_next     = r_state;
        byte_valid = 1'b0;
        byte_ferr  = 1'b0;
        case (r_state)
            R_IDLE:  if (rx_prev && !rx_sync) r_next = R_START;
            R_START: if (tick_half) r_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (tick_bit && bit_idx == 3'd7) r_next = R_STOP;
            R_STOP: begin
                if (tick_bit) begin
                    r_next     = R_IDLE;
                    byte_valid = rx_sync;
                    byte_ferr  = !rx_sync;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            r_state <= r_next;
            if (r_next != r_state || tick_bit || r_state == R_IDLE)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + BCW'(1);
            if (r_state == R_START)
                bit_idx <= '0;
            else if (r_state == R_DATA && tick_bit) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
        end
    end

    p_state_t       p_state, p_next;
    logic [2:0]     idx;
    logic [7:0]     csum;
    logic [7:0]     shadow [8];
    logic [TCW-1:0] to_cnt;
    logic           store, load, abort, timeout_hit;

    assign timeout_hit = (to_cnt == TO_LAST);

    // A received byte takes priority over a timeout expiring in the same cycle.
    always_comb begin
        p_next = p_state;
        store  = 1'b0;
        load   = 1'b0;
        abort  = 1'b0;
        case (p_state)
            P_SYNC: if (byte_valid && rx_shift == SYNC_BYTE) p_next = P_PAYLOAD;
            P_PAYLOAD: begin
                if (byte_ferr)
                    abort = 1'b1;
                else if (byte_valid) begin
                    store = 1'b1;
                    if (idx == 3'd7) p_next = P_CSUM;
                end else if (timeout_hit)
                    abort = 1'b1;
            end
            P_CSUM: begin
                if (byte_ferr)
                    abort = 1'b1;
                else if (byte_valid) begin
                    load   = (rx_shift == csum);
                    abort  = (rx_shift != csum);
                    p_next = P_SYNC;
                end else if (timeout_hit)
                    abort = 1'b1;
            end
            default: p_next = P_SYNC;
        endcase
        if (abort) p_next = P_SYNC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state   <= P_SYNC;
            idx       <= '0;
            csum      <= '0;
            to_cnt    <= '0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
            pu        <= 1'b1;
            per       <= 8'd1;
            p1wid     <= 16'd30;
            del       <= 16'd200;
            p2wid     <= 16'd30;
            cp        <= 1'b1;
            bl        <= 1'b1;
            rxd       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            p_state   <= p_next;
            rxd       <= load;
            frame_err <= abort;
            if (p_state == P_SYNC || byte_valid || byte_ferr || abort)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TCW'(1);
            if (p_state == P_SYNC) begin
                idx  <= '0;
                csum <= '0;
            end else if (store) begin
                shadow[idx] <= rx_shift;
                csum        <= csum ^ rx_shift;
                idx         <= idx + 3'd1;
            end
            if (load) begin
                per   <= shadow[0];
                p1wid <= {shadow[1], shadow[2]};
                del   <= {shadow[3], shadow[4]};
                p2wid <= {shadow[5], shadow[6]};
                pu    <= shadow[7][0];
                cp    <= shadow[7][1];
                bl    <= shadow[7][2];
            end
        end
    end
endmodule

// File: tb/tb_serial_param_loader.sv
// tb/tb_serial_param_loader.sv - scoreboard bench for serial_param_loader
module tb_serial_param_loader;
    localparam int CPB = 16;
    localparam int TO  = 3000;

    logic        clk = 1'b0;
    logic        reset, uart_rx;
    logic        pu, cp, bl, rxd, frame_err;
    logic [7:0]  per;
    logic [15:0] p1wid, del, p2wid;
    logic [58:0] act_params;

    serial_param_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .pu(pu), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .cp(cp), .bl(bl), .rxd(rxd), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign act_params = {per, p1wid, del, p2wid, bl, cp, pu};

    typedef struct {
        bit          is_load;
        logic [7:0]  per;
        logic [15:0] p1, dl, p2;
        logic [2:0]  fl;
    } exp_t;

    typedef struct {
        logic [95:0] bytes;
        int          n;
        int          bad_idx;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    exp_t rst_exp;
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t mk_exp(bit ld, logic [7:0] p, logic [15:0] a, logic [15:0] d,
                                    logic [15:0] b, logic [2:0] f);
        exp_t e;
        e.is_load = ld; e.per = p; e.p1 = a; e.dl = d; e.p2 = b; e.fl = f;
        return e;
    endfunction

    function automatic logic [58:0] pack(exp_t e);
        return {e.per, e.p1, e.dl, e.p2, e.fl};
    endfunction

    function automatic logic [79:0] mk_frame(logic [63:0] pl);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ pl[63-8*i -: 8];
        return {8'hA5, pl, x};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rxd || frame_err) begin
            check("strobe_exclusive", {63'd0, rxd && frame_err}, 64'd0);
            if (sb.size() == 0)
                check("unexpected_strobe", {62'd0, rxd, frame_err}, 64'd0);
            else begin
                e = sb.pop_front();
                check("strobe_kind", {62'd0, rxd, frame_err}, e.is_load ? 64'd2 : 64'd1);
                if (e.is_load && rxd)
                    check("loaded_params", {5'd0, act_params}, {5'd0, pack(e)});
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, bit bad_stop);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CPB);
        end
        uart_rx = !bad_stop;
        idle(CPB);
        if (bad_stop) begin
            uart_rx = 1'b1;
            idle(CPB);
        end
    endtask

    task automatic send_range(logic [79:0] f, int first, int last);
        for (int i = first; i <= last; i++) send_byte(f[79-8*i -: 8], 1'b0);
    endtask

    task automatic settle(string name);
        idle(4 * CPB);
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
        check({name, "_outputs"}, {5'd0, act_params}, {5'd0, pack(cur)});
    endtask

    initial begin
        logic [63:0] pl1, pl2, pl3, pl4;
        logic [79:0] f;
        pl1 = 64'h02_00_28_01_2C_00_32_07;
        pl2 = 64'h05_01_00_00_64_00_0A_03;
        pl3 = 64'hA5_12_34_A5_A5_00_01_F8;
        pl4 = 64'h10_FF_FF_00_00_12_34_06;
        rst_exp = mk_exp(1'b0, 8'd1, 16'd30, 16'd200, 16'd30, 3'b111);

        vecs[0] = '{{mk_frame(pl1), 16'h0}, 10, -1, mk_exp(1'b1, 8'd2, 16'd40, 16'd300, 16'd50, 3'b111)};
        vecs[1] = '{{8'hA5, pl1, 8'h14, 16'h0}, 10, -1, mk_exp(1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 3'b000)};
        vecs[2] = '{{16'h00FF, mk_frame(pl2)}, 12, -1, mk_exp(1'b1, 8'd5, 16'd256, 16'd100, 16'd10, 3'b011)};
        vecs[3] = '{{mk_frame(pl3), 16'h0}, 10, -1, mk_exp(1'b1, 8'hA5, 16'h1234, 16'hA5A5, 16'h0001, 3'b000)};
        vecs[4] = '{{mk_frame(pl1), 16'h0}, 10, 4, mk_exp(1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 3'b000)};
        vecs[5] = '{{mk_frame(pl4), 16'h0}, 10, -1, mk_exp(1'b1, 8'h10, 16'hFFFF, 16'h0000, 16'h1234, 3'b110)};

        reset   = 1'b1;
        uart_rx = 1'b1;
        idle(3);
        cur = rst_exp;
        check("reset_params", {5'd0, act_params}, {5'd0, pack(cur)});
        check("reset_strobes", {62'd0, rxd, frame_err}, 64'd0);
        reset = 1'b0;
        idle(4);

        for (int v = 0; v < 6; v++) begin
            sb.push_back(vecs[v].e);
            if (vecs[v].e.is_load) cur = vecs[v].e;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[95-8*i -: 8], i == vecs[v].bad_idx);
                if (i == vecs[v].bad_idx) break;
            end
            settle($sformatf("vec%0d", v));
        end

        // Partial frame then a long idle: timeout abort, then a good frame.
        sb.push_back(mk_exp(1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 3'b000));
        send_range(mk_frame(pl2), 0, 4);
        idle(TO + 500);
        settle("timeout");
        cur = vecs[0].e;
        sb.push_back(cur);
        send_range(mk_frame(pl1), 0, 9);
        settle("after_timeout");

        // Reset in the middle of payload byte 5.
        send_range(mk_frame(pl4), 0, 4);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = pl4[31-i];
            idle(CPB);
        end
        reset = 1'b1;
        #1;
        check("async_reset_params", {5'd0, act_params}, {5'd0, pack(rst_exp)});
        idle(3);
        uart_rx = 1'b1;
        reset   = 1'b0;
        cur = rst_exp;
        settle("mid_reset");
        cur = vecs[2].e;
        sb.push_back(cur);
        send_range(mk_frame(pl2), 0, 9);
        settle("after_reset");

        // Half-bit glitch inside a frame must not be decoded as a byte.
        cur = vecs[3].e;
        sb.push_back(cur);
        f = mk_frame(pl3);
        send_range(f, 0, 3);
        uart_rx = 1'b0;
        idle(CPB / 2);
        uart_rx = 1'b1;
        idle(12 * CPB);
        send_range(f, 4, 9);
        settle("glitch");

        check("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
